// File: rtl/subservient_dbg_pkg.sv
// Shared encodings for the subservient debug loader: host command bytes,
// response status bytes and the loader FSM states.
package subservient_dbg_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_RUN   = 8'h03;
    localparam logic [7:0] CMD_HALT  = 8'h04;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_CMD = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

endpackage

// File: rtl/subservient_dbg_loader.sv
// Byte-stream loader that owns the subservient debug Wishbone port: it halts or
// releases the core and performs 32-bit reads/writes on behalf of a host.
module subservient_dbg_loader
    import subservient_dbg_pkg::*;
#(
    parameter bit          RESET_HALTED = 1'b1,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_debug_mode,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t          state_q,    state_d;
    logic            is_write_q, is_write_d;
    logic [1:0]      cnt_q,      cnt_d;
    logic [TW-1:0]   tmo_q,      tmo_d;
    logic [31:0]     adr_q,      adr_d;
    logic [31:0]     dat_q,      dat_d;
    logic [31:0]     rdt_q,      rdt_d;
    logic [7:0]      status_q,   status_d;
    logic            multi_q,    multi_d;
    logic            debug_q,    debug_d;
    logic            stb_q,      stb_d;
    logic            we_q,       we_d;
    logic            live_q;

    logic rx_fire;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_CMD;
            is_write_q <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdt_q      <= '0;
            status_q   <= ST_OK;
            multi_q    <= 1'b0;
            debug_q    <= RESET_HALTED;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdt_q      <= rdt_d;
            status_q   <= status_d;
            multi_q    <= multi_d;
            debug_q    <= debug_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            live_q     <= 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdt_d      = rdt_q;
        status_d   = status_q;
        multi_d    = multi_q;
        debug_d    = debug_q;
        stb_d      = stb_q;
        we_d       = we_q;

        // live_q keeps rx_ready low while reset is held and for the release edge
        o_rx_ready = live_q && (state_q == S_CMD || state_q == S_ADDR || state_q == S_DATA);
        rx_fire    = i_rx_valid && o_rx_ready;

        unique case (state_q)
            S_CMD: begin
                if (rx_fire) begin
                    cnt_d    = '0;
                    multi_d  = 1'b0;
                    status_d = ST_OK;
                    case (i_rx_data)
                        CMD_WRITE: begin state_d = S_ADDR; is_write_d = 1'b1; end
                        CMD_READ:  begin state_d = S_ADDR; is_write_d = 1'b0; end
                        CMD_RUN:   begin state_d = S_RESP; debug_d = 1'b0; end
                        CMD_HALT:  begin state_d = S_RESP; debug_d = 1'b1; end
                        default:   begin state_d = S_RESP; status_d = ST_BAD_CMD; end
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d[{cnt_q, 3'b000} +: 8] = i_rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_write_d) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_BUS;
                            stb_d   = 1'b1;
                            we_d    = 1'b0;
                            tmo_d   = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    dat_d[{cnt_q, 3'b000} +: 8] = i_rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            S_BUS: begin
                // ack may arrive combinationally in the very first stb cycle
                if (i_wb_dbg_ack) begin
                    stb_d   = 1'b0;
                    state_d = S_RESP;
                    cnt_d   = '0;
                    if (is_write_q) begin
                        status_d = ST_OK;
                        multi_d  = 1'b0;
                    end else begin
                        rdt_d   = i_wb_dbg_rdt;
                        multi_d = 1'b1;
                    end
                end else if (TIMEOUT != 0) begin
                    if (tmo_q == TMO_LAST) begin
                        stb_d    = 1'b0;
                        state_d  = S_RESP;
                        cnt_d    = '0;
                        status_d = ST_TIMEOUT;
                        multi_d  = 1'b0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (i_tx_ready) begin
                    if (!multi_q || cnt_q == 2'd3) begin
                        state_d = S_CMD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_CMD;
        endcase

        o_tx_valid   = (state_q == S_RESP);
        o_tx_data    = 8'h00;
        if (o_tx_valid) begin
            o_tx_data = multi_q ? rdt_q[{cnt_q, 3'b000} +: 8] : status_q;
        end
        o_debug_mode = debug_q;
        o_wb_dbg_adr = adr_q;
        o_wb_dbg_dat = dat_q;
        o_wb_dbg_we  = we_q;
        o_wb_dbg_stb = stb_q;
        o_wb_dbg_sel = stb_q ? 4'hF : 4'h0;
    end

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Directed bench for the debug loader: a small Wishbone slave model, a bus
// monitor, and a queue of expected response bytes checked at each tx handshake.
module tb_subservient_dbg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        debug_mode;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    always #5 clk = ~clk;

    subservient_dbg_loader #(.RESET_HALTED(1'b1), .TIMEOUT(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_debug_mode (debug_mode),
        .o_wb_dbg_adr (wb_adr),
        .o_wb_dbg_dat (wb_dat),
        .o_wb_dbg_sel (wb_sel),
        .o_wb_dbg_we  (wb_we),
        .o_wb_dbg_stb (wb_stb),
        .i_wb_dbg_rdt (wb_rdt),
        .i_wb_dbg_ack (wb_ack)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave: acks once it has seen ack_delay stb cycles (0 = same cycle)
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    logic        ack_force = 1'b0;
    logic [31:0] rdt_val = 32'h0;
    int          stb_cnt;

    assign wb_rdt = rdt_val;
    assign wb_ack = (wb_stb && ack_en && stb_cnt == ack_delay) || ack_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                stb_cnt <= 0;
        else if (wb_stb && !wb_ack) stb_cnt <= stb_cnt + 1;
        else                       stb_cnt <= 0;
    end

    logic [31:0] exp_adr = 32'h0;
    logic [31:0] exp_dat = 32'h0;
    logic        exp_we = 1'b0;
    int          stb_cycles = 0;
    logic        held = 1'b0;
    logic [7:0]  held_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_stb) begin
                stb_cycles++;
                chk("bus_adr", wb_adr, exp_adr);
                if (exp_we) chk("bus_dat", wb_dat, exp_dat);
                chk("bus_we", 32'(wb_we), 32'(exp_we));
                chk("bus_sel", 32'(wb_sel), 32'hF);
            end
            if (tx_valid) begin
                if (held) chk("tx_stable", 32'(tx_data), 32'(held_data));
                if (tx_ready) begin
                    chk("tx_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = tx_data;
                end
            end else begin
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rx_accept", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic drain(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!tx_valid && w < 200) begin
                @(posedge clk);
                #1 w++;
            end
            chk("tx_valid_seen", 32'(tx_valid), 32'd1);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state, while held and right after release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_debug_mode", 32'(debug_mode), 32'd1);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_sel", 32'(wb_sel), 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("post_rst_debug_mode", 32'(debug_mode), 32'd1);
        chk("post_rst_stb", 32'(wb_stb), 32'd0);
        chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);

        // WRITE, slave acks on the third stb cycle
        exp_adr = 32'h0000_0010; exp_dat = 32'hDEAD_BEEF; exp_we = 1'b1;
        ack_en = 1'b1; ack_delay = 2; stb_cycles = 0;
        exp_q.push_back(8'h00);
        send_byte(8'h01); send_word(32'h0000_0010); send_word(32'hDEAD_BEEF);
        drain(1, 0);
        chk("wr_stb_cycles", 32'(stb_cycles), 32'd3);

        // READ, same-cycle ack, slow host
        exp_we = 1'b0; ack_delay = 0; rdt_val = 32'hDEAD_BEEF; stb_cycles = 0;
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
        send_byte(8'h02); send_word(32'h0000_0010);
        drain(4, 5);
        chk("rd_stb_cycles", 32'(stb_cycles), 32'd1);

        // RUN then HALT
        chk("pre_run_debug", 32'(debug_mode), 32'd1);
        exp_q.push_back(8'h00);
        send_byte(8'h03);
        chk("run_debug", 32'(debug_mode), 32'd0);
        drain(1, 0);
        exp_q.push_back(8'h00);
        send_byte(8'h04);
        chk("halt_debug", 32'(debug_mode), 32'd1);
        drain(1, 0);

        // READ with no ack: timeout after 8 stb cycles
        ack_en = 1'b0; exp_adr = 32'h0000_0020; exp_we = 1'b0; stb_cycles = 0;
        exp_q.push_back(8'hEE);
        send_byte(8'h02); send_word(32'h0000_0020);
        drain(1, 0);
        chk("tmo_stb_cycles", 32'(stb_cycles), 32'd8);
        chk("tmo_back_to_cmd", 32'(rx_ready), 32'd1);
        ack_force = 1'b1;
        @(posedge clk);
        #1 ack_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_no_tx", 32'(tx_valid), 32'd0);
        chk("late_ack_rx_ready", 32'(rx_ready), 32'd1);

        // unknown command
        exp_q.push_back(8'hE1);
        send_byte(8'h55);
        drain(1, 0);

        // reset asserted mid-WRITE while stb is high
        exp_adr = 32'h0000_0040; exp_dat = 32'hCAFE_F00D; exp_we = 1'b1;
        send_byte(8'h01); send_word(32'h0000_0040); send_word(32'hCAFE_F00D);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_stb_high", 32'(wb_stb), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", 32'(wb_stb), 32'd0);
        chk("mid_rst_sel", 32'(wb_sel), 32'd0);
        chk("mid_rst_adr", wb_adr, 32'd0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("after_rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("after_rst_tx_valid", 32'(tx_valid), 32'd0);

        // next WRITE completes normally
        ack_en = 1'b1; ack_delay = 1; stb_cycles = 0;
        exp_adr = 32'h0000_0100; exp_dat = 32'h1234_5678; exp_we = 1'b1;
        exp_q.push_back(8'h00);
        send_byte(8'h01); send_word(32'h0000_0100); send_word(32'h1234_5678);
        drain(1, 0);
        chk("wr2_stb_cycles", 32'(stb_cycles), 32'd2);

        chk("tx_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
